// File: rtl/cdb_arbiter.sv
// Round-robin arbiter with one holding slot per FU in front of the common data bus.
// Latency: handshake in t, broadcast no earlier than t+2; an ungranted FU is held off via fu_ready_o.
module cdb_arbiter #(
    parameter int NUM_FU      = 5,
    parameter int CDB_WIDTH   = 2,
    parameter int PHY_REG_NUM = 8,
    localparam int TAG_W      = $clog2(PHY_REG_NUM),
    localparam int PTR_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_FU-1:0]          fu_valid_i,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag_i,
    output logic [NUM_FU-1:0]          fu_ready_o,
    input  logic                       flush_i,
    output logic [CDB_WIDTH-1:0]       cdb_en_o,
    output logic [CDB_WIDTH*TAG_W-1:0] cdb_tag_o,
    output logic [NUM_FU-1:0]          pend_o
);

    logic [NUM_FU-1:0]          pend_valid;
    logic [TAG_W-1:0]           pend_tag [NUM_FU];
    logic [PTR_W-1:0]           rr_ptr;

    logic [NUM_FU-1:0]          granted;
    logic [CDB_WIDTH-1:0]       lane_en;
    logic [CDB_WIDTH*TAG_W-1:0] lane_tag;
    logic                       any_grant;
    logic [PTR_W-1:0]           next_ptr;
    logic [NUM_FU-1:0]          xfer;

    // Scan from rr_ptr with wrap; the n-th candidate found fills lane n.
    always_comb begin
        int cnt;
        int idx;
        int last_idx;
        granted   = '0;
        lane_en   = '0;
        lane_tag  = '0;
        any_grant = 1'b0;
        cnt       = 0;
        idx       = 0;
        last_idx  = 0;
        for (int j = 0; j < NUM_FU; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (pend_valid[idx] && (cnt < CDB_WIDTH)) begin
                granted[idx]                  = 1'b1;
                lane_en[cnt]                  = 1'b1;
                lane_tag[cnt*TAG_W +: TAG_W]  = pend_tag[idx];
                cnt                           = cnt + 1;
                last_idx                      = idx;
                any_grant                     = 1'b1;
            end
        end
        if (last_idx == NUM_FU - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = PTR_W'(last_idx + 1);
        end
    end

    // A granted slot frees this cycle, so its FU may hand over the next result immediately.
    assign fu_ready_o = flush_i ? '0 : (~pend_valid | granted);
    assign xfer       = fu_valid_i & fu_ready_o;
    assign pend_o     = pend_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= '0;
            rr_ptr     <= '0;
            cdb_en_o   <= '0;
            cdb_tag_o  <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                pend_tag[i] <= '0;
            end
        end else if (flush_i) begin
            pend_valid <= '0;
            rr_ptr     <= '0;
            cdb_en_o   <= '0;
            cdb_tag_o  <= '0;
        end else begin
            cdb_en_o  <= lane_en;
            cdb_tag_o <= lane_tag;
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (xfer[i]) begin
                    pend_valid[i] <= 1'b1;
                    pend_tag[i]   <= fu_tag_i[i*TAG_W +: TAG_W];
                end else if (granted[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, rotation, back-pressure, streaming, flush, async reset.
module tb_cdb_arbiter;

    logic        clk;
    logic        reset;
    logic [4:0]  fu_valid_i;
    logic [14:0] fu_tag_i;
    logic [4:0]  fu_ready_o;
    logic        flush_i;
    logic [1:0]  cdb_en_o;
    logic [5:0]  cdb_tag_o;
    logic [4:0]  pend_o;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(.NUM_FU(5), .CDB_WIDTH(2), .PHY_REG_NUM(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .fu_valid_i (fu_valid_i),
        .fu_tag_i   (fu_tag_i),
        .fu_ready_o (fu_ready_o),
        .flush_i    (flush_i),
        .cdb_en_o   (cdb_en_o),
        .cdb_tag_o  (cdb_tag_o),
        .pend_o     (pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        fu_valid_i = '0;
        fu_tag_i   = '0;
        flush_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        fu_valid_i = '0;
        fu_tag_i   = '0;
        flush_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL reset_en: got %b expected 00", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'd0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", cdb_tag_o); end
        n_checks++; if (pend_o !== 5'b00000) begin n_fail++; $display("FAIL reset_pend: got %b expected 00000", pend_o); end
        n_checks++; if (fu_ready_o !== 5'b11111) begin n_fail++; $display("FAIL reset_ready: got %b expected 11111", fu_ready_o); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        fu_valid_i    = 5'b00100;
        fu_tag_i[6+:3] = 3'd5;
        tick();
        fu_valid_i = '0;
        n_checks++; if (pend_o !== 5'b00100) begin n_fail++; $display("FAIL single_pend: got %b expected 00100", pend_o); end
        n_checks++; if (cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL single_early: got %b expected 00", cdb_en_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b01) begin n_fail++; $display("FAIL single_en: got %b expected 01", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'o05) begin n_fail++; $display("FAIL single_tag: got %o expected 05", cdb_tag_o); end
        // rr_ptr is now 3, so FU4 must beat FU0 to lane 0
        fu_valid_i = 5'b10001;
        fu_tag_i[0+:3]  = 3'd2;
        fu_tag_i[12+:3] = 3'd6;
        tick();
        fu_valid_i = '0;
        tick();
        n_checks++; if (cdb_en_o !== 2'b11) begin n_fail++; $display("FAIL ptr3_en: got %b expected 11", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'o26) begin n_fail++; $display("FAIL ptr3_tag: got %o expected 26", cdb_tag_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL idle_en: got %b expected 00", cdb_en_o); end
    endtask

    task automatic test_all_full();
        apply_reset();
        fu_valid_i = 5'b11111;
        for (int i = 0; i < 5; i++) fu_tag_i[i*3 +: 3] = 3'(i + 1);
        tick();
        fu_valid_i = '0;
        n_checks++; if (pend_o !== 5'b11111) begin n_fail++; $display("FAIL full_pend: got %b expected 11111", pend_o); end
        n_checks++; if (fu_ready_o !== 5'b00011) begin n_fail++; $display("FAIL full_ready0: got %b expected 00011", fu_ready_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b11) begin n_fail++; $display("FAIL full_en1: got %b expected 11", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'o21) begin n_fail++; $display("FAIL full_tag1: got %o expected 21", cdb_tag_o); end
        n_checks++; if (fu_ready_o !== 5'b01111) begin n_fail++; $display("FAIL full_ready1: got %b expected 01111", fu_ready_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b11) begin n_fail++; $display("FAIL full_en2: got %b expected 11", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'o43) begin n_fail++; $display("FAIL full_tag2: got %o expected 43", cdb_tag_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b01) begin n_fail++; $display("FAIL full_en3: got %b expected 01", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'o05) begin n_fail++; $display("FAIL full_tag3: got %o expected 05", cdb_tag_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL full_en4: got %b expected 00", cdb_en_o); end
        n_checks++; if (pend_o !== 5'b00000) begin n_fail++; $display("FAIL full_drain: got %b expected 00000", pend_o); end
    endtask

    task automatic test_wrap();
        fu_valid_i = 5'b01000;
        fu_tag_i[9+:3] = 3'd6;
        tick();
        fu_valid_i = '0;
        tick();
        n_checks++; if (cdb_tag_o !== 6'o06) begin n_fail++; $display("FAIL wrap_pre: got %o expected 06", cdb_tag_o); end
        fu_valid_i = 5'b10011;
        fu_tag_i[0+:3]  = 3'd1;
        fu_tag_i[3+:3]  = 3'd2;
        fu_tag_i[12+:3] = 3'd7;
        tick();
        fu_valid_i = '0;
        tick();
        n_checks++; if (cdb_en_o !== 2'b11) begin n_fail++; $display("FAIL wrap_en1: got %b expected 11", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'o17) begin n_fail++; $display("FAIL wrap_tag1: got %o expected 17", cdb_tag_o); end
        n_checks++; if (pend_o !== 5'b00010) begin n_fail++; $display("FAIL wrap_pend: got %b expected 00010", pend_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b01) begin n_fail++; $display("FAIL wrap_en2: got %b expected 01", cdb_en_o); end
        n_checks++; if (cdb_tag_o !== 6'o02) begin n_fail++; $display("FAIL wrap_tag2: got %o expected 02", cdb_tag_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        fu_valid_i = 5'b00010;
        for (int k = 0; k < 6; k++) begin
            fu_tag_i[3+:3] = 3'(k);
            #1;
            n_checks++; if (fu_ready_o[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, fu_ready_o[1]); end
            tick();
            if (k >= 1) begin
                n_checks++; if (cdb_en_o !== 2'b01 || cdb_tag_o[2:0] !== 3'(k - 1)) begin
                    n_fail++; $display("FAIL b2b_bcast[%0d]: got en=%b tag=%0d expected en=01 tag=%0d", k, cdb_en_o, cdb_tag_o[2:0], k - 1);
                end
            end
        end
        fu_valid_i = '0;
        tick();
        n_checks++; if (cdb_en_o !== 2'b01 || cdb_tag_o[2:0] !== 3'd5) begin n_fail++; $display("FAIL b2b_last: got en=%b tag=%0d expected en=01 tag=5", cdb_en_o, cdb_tag_o[2:0]); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got %b expected 00", cdb_en_o); end
    endtask

    task automatic test_flush();
        fu_valid_i = 5'b10101;
        fu_tag_i[0+:3]  = 3'd1;
        fu_tag_i[6+:3]  = 3'd3;
        fu_tag_i[12+:3] = 3'd5;
        tick();
        fu_valid_i = 5'b01000;
        fu_tag_i[9+:3] = 3'd6;
        flush_i = 1'b1;
        #1;
        n_checks++; if (fu_ready_o !== 5'b00000) begin n_fail++; $display("FAIL flush_ready: got %b expected 00000", fu_ready_o); end
        tick();
        flush_i = 1'b0;
        n_checks++; if (cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL flush_en: got %b expected 00", cdb_en_o); end
        n_checks++; if (pend_o !== 5'b00000) begin n_fail++; $display("FAIL flush_pend: got %b expected 00000", pend_o); end
        #1;
        n_checks++; if (fu_ready_o[3] !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready: got %b expected 1", fu_ready_o[3]); end
        tick();
        fu_valid_i = '0;
        n_checks++; if (pend_o !== 5'b01000 || cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL flush_accept: got pend=%b en=%b expected pend=01000 en=00", pend_o, cdb_en_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b01 || cdb_tag_o !== 6'o06) begin n_fail++; $display("FAIL flush_bcast: got en=%b tag=%o expected en=01 tag=06", cdb_en_o, cdb_tag_o); end
        tick();
    endtask

    task automatic test_async_reset();
        fu_valid_i = 5'b00111;
        fu_tag_i[0+:3] = 3'd7;
        fu_tag_i[3+:3] = 3'd6;
        fu_tag_i[6+:3] = 3'd5;
        tick();
        fu_valid_i = '0;
        tick();
        n_checks++; if (cdb_en_o !== 2'b11 || cdb_tag_o !== 6'o67 || pend_o !== 5'b00100) begin
            n_fail++; $display("FAIL arst_pre: got en=%b tag=%o pend=%b expected en=11 tag=67 pend=00100", cdb_en_o, cdb_tag_o, pend_o);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (cdb_en_o !== 2'b00 || cdb_tag_o !== 6'd0 || pend_o !== 5'b00000) begin
            n_fail++; $display("FAIL arst_clear: got en=%b tag=%o pend=%b expected all zero", cdb_en_o, cdb_tag_o, pend_o);
        end
        #1;
        reset = 1'b0;
        tick();
        n_checks++; if (cdb_en_o !== 2'b00) begin n_fail++; $display("FAIL arst_stale1: got %b expected 00", cdb_en_o); end
        tick();
        n_checks++; if (cdb_en_o !== 2'b00 || pend_o !== 5'b00000) begin n_fail++; $display("FAIL arst_stale2: got en=%b pend=%b expected 00/00000", cdb_en_o, pend_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_full();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
